otter_intr_ctrl: RTL
====================

OTTER_INTR_CTRL -- requirements
Module: otter_intr_ctrl

Interface
REQ-001 Parameter N_SRC, default 4, is the number of interrupt sources; the legal range SHALL be 2..8.
REQ-002 Clock and reset SHALL be one clock and a synchronous active-low reset.
- clk  in  1  sole clock; all state changes on its rising edge.
- RST_N  in  1  synchronous active-low reset.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- irq_src  in  N_SRC  raw interrupt lines, rising-edge triggered.
- mie  in  1  global interrupt enable from the CSR file.
- int_taken  in  1  one-cycle pulse from the control FSM when it enters its interrupt state.
- mret_exec  in  1  one-cycle pulse from the control FSM when it executes MRET.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  configuration register select.
- cfg_wdata  in  8  configuration write data.
- cfg_rdata  out  8  configuration read data, combinational from cfg_addr.
- intr  out  1  interrupt request to the control FSM.
- irq_id  out  3  index of the source being requested or serviced, for mcause.

Function
REQ-004 Edge detect: a pending[i] bit SHALL be set one cycle after irq_src[i] is sampled 0 and then 1 on consecutive edges.
REQ-005 Register map:
- addr 0: ENABLE[N_SRC-1:0], read/write.
- addr 1: PENDING, read; a write clears each bit written as 1.
- addr 2: {state[1:0], irq_id[2:0]}, read-only.
- addr 3: reads 0, writes ignored.
- Unused upper bits read 0.
REQ-006 State machine states SHALL be ST_IDLE, ST_REQ and ST_SERV.
REQ-007 ST_IDLE transition: when mie=1 and (pending & ENABLE) != 0, go to ST_REQ.
- irq_id SHALL be latched to the lowest set index; index 0 has the highest priority.
REQ-008 ST_REQ: intr=1, decoded from the state register, so it is glitch-free.
- int_taken=1: clear pending[irq_id] and go to ST_SERV.
REQ-009 ST_REQ withdraw: when mie=0 or ENABLE[irq_id]=0, and int_taken=0 in that cycle, return to ST_IDLE.
- int_taken in the same cycle SHALL take precedence over the withdraw.
REQ-010 ST_SERV: intr=0 and irq_id is held.
- mret_exec=1: go to ST_IDLE. No nesting; new edges only accumulate in pending.
REQ-011 Latency: a source edge sampled at edge t SHALL give pending at t+1 and intr=1 at t+2 (idle, mie=1, source enabled).
REQ-012 A set from a new edge and a clear (int_taken or a W1C write) on the same bit in the same cycle: the set SHALL win.
REQ-013 An int_taken or mret_exec pulse arriving in a state that does not expect it SHALL be ignored.
REQ-014 irq_id SHALL change only on the ST_IDLE->ST_REQ transition.

Reset
REQ-015 RST_N=0 at a clock edge SHALL force, at that edge:
- state ST_IDLE, intr 0, irq_id 0;
- ENABLE 0, PENDING 0;
- edge-detect history 0;
- with the synchronizer compiled in (REQ-017), the synchronizer flops 0.
REQ-016 Reset asserted in any state, including ST_REQ and ST_SERV, SHALL abandon the transaction with no residual pending bits.

Configuration
REQ-017 Macro OTTER_INTR_SYNC_EN:
- Defined: a two-flop synchronizer precedes edge detect on each irq_src bit, and the REQ-011 latency becomes intr at t+4.
- Undefined: irq_src feeds edge detect directly and the sources are assumed synchronous to clk.

Structure
REQ-018 Shared package otter_intr_pkg SHALL hold:
- the state enum (ST_IDLE, ST_REQ, ST_SERV);
- register address constants ADDR_ENABLE=0, ADDR_PENDING=1, ADDR_STATUS=2;
- the N_SRC maximum, 8.
REQ-019 Sub-module otter_intr_prio_enc SHALL be the combinational lowest-index priority encoder (N_SRC-bit vector -> 3-bit index plus valid); all other logic is in otter_intr_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N_SRC=4):
- ENABLE=0x0F, mie=1, rising edge on irq_src[2] -> pending=0x4 one cycle later, intr=1 and irq_id=2 two cycles after the edge; int_taken pulse -> pending=0x0, intr=0, ST_SERV; mret_exec -> ST_IDLE.
- Edges on irq_src[3] and irq_src[1] in the same cycle -> irq_id=1 serviced first; after mret_exec, irq_id=3 requested with intr=1 two cycles later.
- In ST_REQ for source 0, drop mie to 0 with no int_taken -> intr=0 next cycle, pending[0] stays 1; raise mie -> intr=1 again, irq_id=0.
- New edge on irq_src[1] in the same cycle as int_taken for source 1 -> pending[1]=1 afterwards (set wins).
- RST_N=0 for one cycle while in ST_SERV with pending=0xA -> next cycle intr=0, irq_id=0, pending=0, ENABLE=0, cfg_rdata at addr 2 = 0.
- OTTER_INTR_SYNC_EN defined, edge on irq_src[0] -> intr=1 exactly four cycles after the edge; write 0x01 to addr 1 while in ST_IDLE with ENABLE=0 -> pending[0] cleared.

Source files
------------

// File: rtl/otter_intr_pkg.sv
// otter_intr_pkg
//   Shared types and constants for the OTTER interrupt controller slice.
//   - state_e      : controller state encoding (also visible in the STATUS register)
//   - ADDR_*       : configuration register addresses
//   - N_SRC_MAX    : upper bound on the number of interrupt sources
//   - IDX_W        : width of a source index (enough for N_SRC_MAX sources)
package otter_intr_pkg;

  localparam int N_SRC_MAX = 8;
  localparam int IDX_W     = 3;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

endpackage

// File: rtl/otter_intr_prio_enc.sv
// otter_intr_prio_enc
//   Combinational priority encoder: the lowest set index wins.
//   Ports:
//     req_i  in  N_SRC  request vector
//     idx_o  out IDX_W  index of the lowest set bit (0 when nothing is set)
//     vld_o  out 1      at least one request bit is set
module otter_intr_prio_enc
  import otter_intr_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl
//   Edge-triggered interrupt controller for the OTTER core. Rising edges on
//   irq_src latch pending bits; the lowest enabled pending source is
//   requested from the control FSM and tracked until MRET.
//
//   Build option: define OTTER_INTR_SYNC_EN to put a two-flop synchronizer
//   in front of edge detection (adds two cycles of latency). Without it the
//   sources must already be synchronous to clk.
//
//   Ports:
//     clk        in   1      clock, rising edge
//     RST_N      in   1      synchronous active-low reset
//     irq_src    in   N_SRC  raw interrupt lines (rising-edge triggered)
//     mie        in   1      global interrupt enable
//     int_taken  in   1      pulse: control FSM entered its interrupt state
//     mret_exec  in   1      pulse: control FSM executed MRET
//     cfg_we     in   1      configuration write strobe
//     cfg_addr   in   2      configuration register select
//     cfg_wdata  in   8      configuration write data
//     cfg_rdata  out  8      configuration read data (combinational)
//     intr       out  1      interrupt request
//     irq_id     out  3      index of the requested / serviced source
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | nothing outstanding; watching for an enabled pending source
//   ST_REQ  | intr asserted for irq_id; waiting for int_taken
//   ST_SERV | handler running for irq_id; waiting for mret_exec
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mie,
  input  logic             int_taken,
  input  logic             mret_exec,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             intr,
  output logic [2:0]       irq_id
);

  if (N_SRC < 2 || N_SRC > N_SRC_MAX) begin : g_bad_n_src
    $error("otter_intr_ctrl: N_SRC must be in 2..8");
  end

  localparam logic [N_SRC-1:0] SRC_ONE = N_SRC'(1);

  state_e             state_q, state_d;
  logic [2:0]         irq_id_q;
  logic [N_SRC-1:0]   src_in;
  logic [N_SRC-1:0]   src_q, hist_q;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   enable_q, enable_d;
  logic [N_SRC-1:0]   clr;
  logic [N_SRC-1:0]   req_masked;
  logic [N_SRC-1:0]   sel_oh;
  logic               sel_en;
  logic [2:0]         enc_idx;
  logic               enc_vld;
  logic               take;
  logic               load_id;
  logic               unused_wdata;

  // Only the low N_SRC bits of write data reach a register.
  assign unused_wdata = ^cfg_wdata;

`ifdef OTTER_INTR_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = irq_src;
`endif

  // Sample flop plus history flop: rise is built only from registered
  // values so pending never depends combinationally on the raw pins.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      src_q  <= '0;
      hist_q <= '0;
    end else begin
      src_q  <= src_in;
      hist_q <= src_q;
    end
  end

  assign rise = src_q & ~hist_q;

  assign req_masked = pending_q & enable_q;

  otter_intr_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req_i (req_masked),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  assign sel_oh  = SRC_ONE << irq_id_q;
  assign sel_en  = |(enable_q & sel_oh);
  assign take    = (state_q == ST_REQ) && int_taken;
  assign load_id = (state_q == ST_IDLE) && mie && enc_vld;

  // Configuration writes and pending update. A new edge is OR-ed in after
  // the clears so a simultaneous set always survives.
  always_comb begin
    enable_d = enable_q;
    clr      = '0;
    if (cfg_we && cfg_addr == ADDR_ENABLE) begin
      enable_d = cfg_wdata[N_SRC-1:0];
    end
    if (cfg_we && cfg_addr == ADDR_PENDING) begin
      clr = cfg_wdata[N_SRC-1:0];
    end
    if (take) begin
      clr = clr | sel_oh;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      enable_q  <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      if (load_id) begin
        irq_id_q <= enc_idx;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. int_taken is checked before the withdraw condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_id) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (int_taken)          state_d = ST_SERV;
        else if (!mie || !sel_en) state_d = ST_IDLE;
      end
      ST_SERV: begin
        if (mret_exec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs, decoded from registered state only.
  always_comb begin
    intr   = (state_q == ST_REQ);
    irq_id = irq_id_q;
  end

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = 8'(enable_q);
      ADDR_PENDING: cfg_rdata = 8'(pending_q);
      ADDR_STATUS:  cfg_rdata = {3'b000, state_q, irq_id_q};
      default:      cfg_rdata = 8'h00;
    endcase
  end

endmodule
